crono_ctrl: RTL

CRONO_CTRL -- requirements
Module: crono_ctrl

---
 rtl/crono_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/crono_ctrl.sv
// crono_ctrl: stopwatch control FSM with button edge detection,
// load/clear pulse generation and count-enable gating.
module crono_ctrl #(
    parameter int PULSE_LEN = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       STOP,
    input  logic       CLEAR,
    input  logic       LOAD,
    input  logic       TICK,
    input  logic       MAX,
    output logic       P,
    output logic       ZERO,
    output logic       CNT_EN,
    output logic       RUNNING,
    output logic       DONE,
    output logic [2:0] STATE
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4,
        S_CLR   = 3'd5
    } state_t;

    localparam logic [3:0] PULSE_INIT = 4'(PULSE_LEN - 1);

    state_t     state;
    state_t     state_n;
    logic [3:0] cnt;
    logic [3:0] cnt_n;

    logic start_q;
    logic stop_q;
    logic clear_q;
    logic load_q;

    // Raw rising-edge events.
    logic ev_start;
    logic ev_stop;
    logic ev_clear;
    logic ev_load;

    // Events after priority: only the highest one survives.
    logic clr;
    logic ld;
    logic stp;
    logic sta;

    assign ev_start = START & ~start_q;
    assign ev_stop  = STOP  & ~stop_q;
    assign ev_clear = CLEAR & ~clear_q;
    assign ev_load  = LOAD  & ~load_q;

    assign clr = ev_clear;
    assign ld  = ev_load  & ~ev_clear;
    assign stp = ev_stop  & ~ev_clear & ~ev_load;
    assign sta = ev_start & ~ev_clear & ~ev_load & ~ev_stop;

    // Button copies; reset high so a held button needs a fresh press.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            start_q <= 1'b1;
            stop_q  <= 1'b1;
            clear_q <= 1'b1;
            load_q  <= 1'b1;
        end else begin
            start_q <= START;
            stop_q  <= STOP;
            clear_q <= CLEAR;
            load_q  <= LOAD;
        end
    end

    // State and pulse counter registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state and pulse counter logic.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (state == S_CLR) begin
            if (cnt == 4'd0) state_n = S_IDLE;
            else             cnt_n   = cnt - 4'd1;
        end else if (clr) begin
            state_n = S_CLR;
            cnt_n   = PULSE_INIT;
        end else if (state == S_LOAD) begin
            if (cnt == 4'd0) state_n = S_PAUSE;
            else             cnt_n   = cnt - 4'd1;
        end else if (ld) begin
            state_n = S_LOAD;
            cnt_n   = PULSE_INIT;
        end else begin
            case (state)
                S_IDLE: begin
                    if (sta) state_n = S_RUN;
                end
                S_RUN: begin
                    if (stp)              state_n = S_PAUSE;
                    else if (TICK && MAX) state_n = S_DONE;
                end
                S_PAUSE: begin
                    if (sta) state_n = MAX ? S_DONE : S_RUN;
                end
                S_DONE: begin
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    assign P       = (state == S_LOAD) || (state == S_CLR);
    assign ZERO    = (state == S_CLR);
    assign RUNNING = (state == S_RUN);
    assign DONE    = (state == S_DONE);
    assign CNT_EN  = TICK & ~MAX & (state == S_RUN);
    assign STATE   = state;

endmodule
